skullfet_wb_tester: RTL and testbench

Wishbone-controlled stimulus/response tester for the SkullFET inverter cell inside the user project wrapper. It responds to management-core Wishbone transactions and drives a programmable stimulus onto `stim_o`, which is routed to the inverter input. It also samples the inverter output on `resp_i` and reports edge counts, propagation latency in clocks, and error flags. It is the controlling end of the inverter test path: it generates what the cell consumes and checks what the cell produces.

---
 rtl/skullfet_wb_tester.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_skullfet_wb_tester.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/skullfet_wb_tester.sv
`default_nettype none
// ============================================================================
// Module   : skullfet_wb_tester
// Purpose  : Wishbone-controlled stimulus/response tester for the SkullFET
//            inverter cell. Drives a programmable stimulus (static level or
//            divided toggle) onto stim_o. Samples the inverter output on
//            resp_i through a 2-flop synchronizer. Counts stimulus and
//            response edges, measures stimulus-to-response latency in clocks
//            and flags timeouts and polarity mismatches.
// Ports    : wb_clk_i / wb_rst_n      - clock, async active-low reset
//            wbs_*                    - Wishbone classic slave, 32-byte window
//            stim_o                   - registered stimulus to inverter input
//            resp_i                   - inverter output (asynchronous)
//            irq_o                    - level interrupt (registered)
// Register map (offset = adr[4:2]):
//            0 CTRL  {IE, CLR, LEVEL, MODE, EN}   1 DIV[15:0]
//            2 STIM_CNT   3 RESP_CNT   4 LAT[15:0]
//            5 STATUS {MISMATCH, TIMEOUT, resp_sync, stim}   6..7 read 0
// Revision : 1.0 - initial release
// ============================================================================
module skullfet_wb_tester #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [15:0] DIV_RESET = 16'h0010
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        stim_o,
    input  logic        resp_i,
    output logic        irq_o
);

    localparam logic [2:0]  OFF_CTRL     = 3'd0;
    localparam logic [2:0]  OFF_DIV      = 3'd1;
    localparam logic [2:0]  OFF_STIM_CNT = 3'd2;
    localparam logic [2:0]  OFF_RESP_CNT = 3'd3;
    localparam logic [2:0]  OFF_LAT      = 3'd4;
    localparam logic [2:0]  OFF_STATUS   = 3'd5;
    localparam logic [15:0] LAT_LAST     = 16'hFFFE;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic        ack_q;
    logic [31:0] dat_q,      dat_d;
    logic        en_q,       en_d;
    logic        mode_q,     mode_d;
    logic        level_q,    level_d;
    logic        ie_q,       ie_d;
    logic [15:0] div_q,      div_d;
    logic [15:0] divcnt_q,   divcnt_d;
    logic        stim_q,     stim_d;
    logic        s1_q,       s2_q;
    logic [31:0] stim_cnt_q, stim_cnt_d;
    logic [31:0] resp_cnt_q, resp_cnt_d;
    logic [15:0] lat_q,      lat_d;
    logic [15:0] lat_cnt_q,  lat_cnt_d;
    logic        wait_q,     wait_d;
    logic        timeout_q,  timeout_d;
    logic        mismatch_q, mismatch_d;
    logic        irq_q,      irq_d;

    // ------------------------------------------------------------------
    // Bus decode. A request is accepted on the cycle ack rises, so every
    // write side effect lands on that same edge.
    // ------------------------------------------------------------------
    logic       hit;
    logic       req;
    logic       wr;
    logic       rd;
    logic [2:0] off;
    logic       clr;
    logic       w1c_timeout;
    logic       w1c_mismatch;

    assign hit          = (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
    assign req          = wbs_cyc_i & wbs_stb_i & hit & ~ack_q;
    assign wr           = req & wbs_we_i;
    assign rd           = req & ~wbs_we_i;
    assign off          = wbs_adr_i[4:2];
    assign clr          = wr & (off == OFF_CTRL)   & wbs_sel_i[0] & wbs_dat_i[3];
    assign w1c_timeout  = wr & (off == OFF_STATUS) & wbs_sel_i[0] & wbs_dat_i[2];
    assign w1c_mismatch = wr & (off == OFF_STATUS) & wbs_sel_i[0] & wbs_dat_i[3];

    // Byte lanes the block never consumes.
    logic unused_bits;
    assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i[31:16], wbs_sel_i[3:2]};

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_comb begin
        en_d    = en_q;
        mode_d  = mode_q;
        level_d = level_q;
        ie_d    = ie_q;
        div_d   = div_q;
        if (wr && (off == OFF_CTRL) && wbs_sel_i[0]) begin
            en_d    = wbs_dat_i[0];
            mode_d  = wbs_dat_i[1];
            level_d = wbs_dat_i[2];
            ie_d    = wbs_dat_i[4];
        end
        if (wr && (off == OFF_DIV)) begin
            if (wbs_sel_i[0]) div_d[7:0]  = wbs_dat_i[7:0];
            if (wbs_sel_i[1]) div_d[15:8] = wbs_dat_i[15:8];
        end
    end

    // ------------------------------------------------------------------
    // Stimulus generator
    // ------------------------------------------------------------------
    logic [15:0] div_last;
    logic        stim_edge;

    // DIV of 0 is treated as 1, i.e. terminal count 0.
    assign div_last = (div_q == 16'd0) ? 16'd0 : (div_q - 16'd1);

    always_comb begin
        stim_d   = stim_q;
        divcnt_d = divcnt_q;
        if (!en_q) begin
            stim_d   = 1'b0;
            divcnt_d = 16'd0;
        end else if (!mode_q) begin
            stim_d   = level_q;
            divcnt_d = 16'd0;
        end else if (divcnt_q >= div_last) begin
            // >= so a DIV reduced below the running count still wraps
            divcnt_d = 16'd0;
            stim_d   = ~stim_q;
        end else begin
            divcnt_d = divcnt_q + 16'd1;
        end
    end

    assign stim_edge = (stim_d != stim_q);

    // ------------------------------------------------------------------
    // Response path and latency measurement. The edge is detected as s2
    // changes (s1 != s2), so a zero-delay loopback reports 2 clocks.
    // ------------------------------------------------------------------
    logic resp_edge;
    logic timeout_set;
    logic mismatch_set;

    assign resp_edge = s1_q ^ s2_q;

    always_comb begin
        lat_cnt_d    = lat_cnt_q;
        wait_d       = wait_q;
        lat_d        = lat_q;
        timeout_set  = 1'b0;
        mismatch_set = 1'b0;

        if (wait_q) begin
            lat_cnt_d = lat_cnt_q + 16'd1;
            if ((lat_cnt_q == LAT_LAST) && !resp_edge) begin
                timeout_set = 1'b1;
                wait_d      = 1'b0;
            end
        end

        if (resp_edge) begin
            if (wait_q) begin
                // Captured value counts this clock, matching the counter's next value.
                lat_d  = lat_cnt_q + 16'd1;
                wait_d = 1'b0;
            end
            // New s2 (= s1) must be the complement of the current stimulus.
            if (s1_q == stim_q) begin
                mismatch_set = 1'b1;
            end
        end

        if (stim_edge) begin
            lat_cnt_d = 16'd0;
            wait_d    = 1'b1;
        end

        if (clr) begin
            lat_d  = 16'd0;
            wait_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Counters, sticky flags, interrupt
    // ------------------------------------------------------------------
    always_comb begin
        stim_cnt_d = stim_cnt_q;
        resp_cnt_d = resp_cnt_q;
        if (stim_edge) stim_cnt_d = stim_cnt_q + 32'd1;
        if (resp_edge) resp_cnt_d = resp_cnt_q + 32'd1;
        if (clr) begin
            stim_cnt_d = 32'd0;
            resp_cnt_d = 32'd0;
        end
        // Clearing a bit beats a same-cycle set only for that bit.
        timeout_d  = (timeout_q  | timeout_set)  & ~w1c_timeout;
        mismatch_d = (mismatch_q | mismatch_set) & ~w1c_mismatch;
        irq_d      = ie_q & (timeout_q | mismatch_q);
    end

    // ------------------------------------------------------------------
    // Read data: driven only alongside ack, zero otherwise.
    // ------------------------------------------------------------------
    always_comb begin
        dat_d = 32'd0;
        if (rd) begin
            case (off)
                OFF_CTRL:     dat_d = {27'd0, ie_q, 1'b0, level_q, mode_q, en_q};
                OFF_DIV:      dat_d = {16'd0, div_q};
                OFF_STIM_CNT: dat_d = stim_cnt_q;
                OFF_RESP_CNT: dat_d = resp_cnt_q;
                OFF_LAT:      dat_d = {16'd0, lat_q};
                OFF_STATUS:   dat_d = {28'd0, mismatch_q, timeout_q, s2_q, stim_q};
                default:      dat_d = 32'd0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            ack_q      <= 1'b0;
            dat_q      <= 32'd0;
            en_q       <= 1'b0;
            mode_q     <= 1'b0;
            level_q    <= 1'b0;
            ie_q       <= 1'b0;
            div_q      <= DIV_RESET;
            divcnt_q   <= 16'd0;
            stim_q     <= 1'b0;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            stim_cnt_q <= 32'd0;
            resp_cnt_q <= 32'd0;
            lat_q      <= 16'd0;
            lat_cnt_q  <= 16'd0;
            wait_q     <= 1'b0;
            timeout_q  <= 1'b0;
            mismatch_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            ack_q      <= req;
            dat_q      <= dat_d;
            en_q       <= en_d;
            mode_q     <= mode_d;
            level_q    <= level_d;
            ie_q       <= ie_d;
            div_q      <= div_d;
            divcnt_q   <= divcnt_d;
            stim_q     <= stim_d;
            s1_q       <= resp_i;
            s2_q       <= s1_q;
            stim_cnt_q <= stim_cnt_d;
            resp_cnt_q <= resp_cnt_d;
            lat_q      <= lat_d;
            lat_cnt_q  <= lat_cnt_d;
            wait_q     <= wait_d;
            timeout_q  <= timeout_d;
            mismatch_q <= mismatch_d;
            irq_q      <= irq_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign stim_o    = stim_q;
    assign irq_o     = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_skullfet_wb_tester.sv
`default_nettype none
// ============================================================================
// Module   : tb_skullfet_wb_tester
// Purpose  : Self-checking bench for skullfet_wb_tester. The inverter cell is
//            modelled as a selectable zero-delay path (tied low, inverter,
//            buffer). Expected values come from clock-edge arithmetic on the
//            programmed divider and the bench's own edge counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_skullfet_wb_tester;

    localparam logic [31:0] BASE     = 32'h3000_0000;
    localparam logic [2:0]  R_CTRL   = 3'd0;
    localparam logic [2:0]  R_DIV    = 3'd1;
    localparam logic [2:0]  R_STIM   = 3'd2;
    localparam logic [2:0]  R_RESP   = 3'd3;
    localparam logic [2:0]  R_LAT    = 3'd4;
    localparam logic [2:0]  R_STATUS = 3'd5;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc   = 1'b0;
    logic        stb   = 1'b0;
    logic        we    = 1'b0;
    logic [3:0]  sel   = 4'h0;
    logic [31:0] adr   = 32'd0;
    logic [31:0] wdat  = 32'd0;
    logic        ack;
    logic [31:0] dat_o;
    logic        stim;
    logic        resp;
    logic        irq;

    int checks    = 0;
    int failures  = 0;
    int edge_no   = 0;
    int last_edge = 0;
    int resp_mode = 0;   // 0 tied low, 1 inverter, 2 buffer

    always #5 clk = ~clk;
    always @(posedge clk) edge_no <= edge_no + 1;

    assign resp = (resp_mode == 1) ? ~stim : (resp_mode == 2) ? stim : 1'b0;

    skullfet_wb_tester dut (
        .wb_clk_i  (clk),
        .wb_rst_n  (rst_n),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_o),
        .stim_o    (stim),
        .resp_i    (resp),
        .irq_o     (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One classic cycle; returns at the negedge where ack was seen.
    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] r, output logic acked);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        acked = 1'b0;
        r     = 32'd0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                acked     = 1'b1;
                r         = dat_o;
                last_edge = edge_no;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [2:0] o, input logic [31:0] d);
        logic [31:0] r;
        logic        ok;
        wb_xfer(1'b1, BASE + {27'd0, o, 2'b00}, d, 4'hF, r, ok);
        check("write_ack", {31'd0, ok}, 32'd1);
    endtask

    task automatic rd_check(input string tag, input logic [2:0] o, input logic [31:0] exp);
        logic [31:0] r;
        logic        ok;
        wb_xfer(1'b0, BASE + {27'd0, o, 2'b00}, 32'd0, 4'hF, r, ok);
        check({tag, "_ack"}, {31'd0, ok}, 32'd1);
        check(tag, r, exp);
    endtask

    // Write that lands exactly on clock edge 'target'.
    task automatic wr_at(input int target, input logic [2:0] o, input logic [31:0] d);
        for (int i = 0; i < 100000 && edge_no < target - 2; i++) @(negedge clk);
        wr(o, d);
        check("timed_write_edge", 32'(last_edge), 32'(target));
    endtask

    initial begin
        logic [31:0] r;
        logic        ok;
        logic [31:0] rnd;
        logic [3:0]  rsel;
        logic [15:0] div_model;
        int          e0;
        int          d;
        int          t;
        int          off;
        int          exp_stim;
        int          rise;

        // ---------------- reset and register access ----------------
        wait_clk(3);
        rst_n = 1'b1;
        for (int o = 0; o < 8; o++) begin
            rd_check("reset_read", 3'(o), (o == 1) ? 32'h10 : 32'h0);
        end
        wait_clk(1);
        check("dat_idle_zero", dat_o, 32'd0);

        div_model = 16'h0010;
        wb_xfer(1'b1, BASE + 32'h4, 32'h0000_ABCD, 4'b0001, r, ok);
        div_model[7:0] = 8'hCD;
        rd_check("div_sel_byte0", R_DIV, 32'h0000_00CD);
        for (int k = 0; k < 4; k++) begin
            rnd  = $urandom;
            rsel = 4'($urandom_range(0, 15));
            wb_xfer(1'b1, BASE + 32'h4, rnd, rsel, r, ok);
            if (rsel[0]) div_model[7:0]  = rnd[7:0];
            if (rsel[1]) div_model[15:8] = rnd[15:8];
            rd_check("div_rand_sel", R_DIV, {16'd0, div_model});
        end
        wr(R_STIM, 32'hFFFF_FFFF);
        rd_check("ro_stim_cnt", R_STIM, 32'd0);
        wr(3'd7, 32'hFFFF_FFFF);
        rd_check("offset7_read", 3'd7, 32'd0);
        wb_xfer(1'b0, BASE + 32'h20, 32'd0, 4'hF, r, ok);
        check("out_of_window_noack", {31'd0, ok}, 32'd0);

        // ---------------- toggle loopback through an inverter ----------------
        resp_mode = 1;
        wait_clk(4);
        wr(R_STATUS, 32'hC);
        for (int it = 0; it < 3; it++) begin
            d   = (it == 0) ? 4  : int'($urandom_range(2, 9));
            t   = (it == 0) ? 10 : int'($urandom_range(5, 12));
            off = (it == 0) ? 2  : int'($urandom_range(1, d - 1));
            wr(R_CTRL, 32'h8);
            wr(R_DIV, 32'(d));
            wr(R_CTRL, 32'h3);
            e0 = last_edge;
            // toggles at e0 + d*j; disable lands between two toggles
            wr_at(e0 + d * t + off, R_CTRL, 32'h0);
            wait_clk(6);
            exp_stim = t + (t % 2);   // odd toggle count leaves stim high -> disable edge
            rd_check("loop_stim_cnt", R_STIM, 32'(exp_stim));
            rd_check("loop_resp_cnt", R_RESP, 32'(exp_stim));
            rd_check("loop_lat", R_LAT, 32'd2);
            rd_check("loop_status", R_STATUS, 32'h2);
        end

        // ---------------- mismatch through a buffer ----------------
        resp_mode = 2;
        wr(R_DIV, 32'h40);
        wait_clk(4);
        wr(R_STATUS, 32'hC);
        rd_check("mm_pre_status", R_STATUS, 32'h0);
        wr(R_CTRL, 32'h17);
        wait_clk(70);
        rd_check("mm_status", R_STATUS, 32'hB);
        check("mm_irq_set", {31'd0, irq}, 32'd1);
        wr(R_CTRL, 32'h15);
        wr(R_STATUS, 32'h8);
        check("mm_irq_hold", {31'd0, irq}, 32'd1);
        wait_clk(1);
        check("mm_irq_clear", {31'd0, irq}, 32'd0);
        rd_check("mm_status_clear", R_STATUS, 32'h3);

        // ---------------- timeout with response tied low ----------------
        wr(R_CTRL, 32'h0);
        wait_clk(4);
        resp_mode = 0;
        wr(R_STATUS, 32'hC);
        wr(R_CTRL, 32'h8);
        rd_check("to_lat_pre", R_LAT, 32'd0);
        wr(R_CTRL, 32'h15);
        e0   = last_edge;
        rise = -1;
        for (int i = 0; i < 70000; i++) begin
            @(negedge clk);
            if (irq === 1'b1) begin
                rise = edge_no;
                break;
            end
        end
        // stim edge at e0+1, TIMEOUT 65535 clocks later, irq one clock after
        check("to_irq_edge", 32'(rise - e0), 32'd65537);
        rd_check("to_status", R_STATUS, 32'h5);
        rd_check("to_lat_unchanged", R_LAT, 32'd0);
        rd_check("to_stim_cnt", R_STIM, 32'd1);
        wr(R_STATUS, 32'h4);
        wait_clk(1);
        check("to_irq_clear", {31'd0, irq}, 32'd0);
        rd_check("to_status_clear", R_STATUS, 32'h1);

        // ---------------- CLR on the same edge as a stimulus toggle ----------------
        wr(R_CTRL, 32'h0);
        wr(R_DIV, 32'h40);
        wr(R_CTRL, 32'h3);
        e0 = last_edge;
        wr_at(e0 + 64, R_CTRL, 32'hB);
        rd_check("clr_race_stim_cnt", R_STIM, 32'd0);
        rd_check("clr_reads_zero", R_CTRL, 32'h3);
        rd_check("clr_race_stim_high", R_STATUS, 32'h1);

        // ---------------- asynchronous reset mid-transaction ----------------
        resp_mode = 1;
        wr(R_CTRL, 32'h0);
        wr(R_DIV, 32'h3);
        wr(R_CTRL, 32'h3);
        wait_clk(4 + int'($urandom_range(0, 5)));
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h8; sel = 4'hF;
        @(negedge clk);
        check("rst_pre_ack", {31'd0, ack}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_dat", dat_o, 32'd0);
        check("rst_stim", {31'd0, stim}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        resp_mode = 0;
        cyc = 1'b0; stb = 1'b0;
        wait_clk(2);
        rst_n = 1'b1;
        rd_check("rst_div", R_DIV, 32'h10);
        rd_check("rst_ctrl", R_CTRL, 32'h0);
        rd_check("rst_stim_cnt", R_STIM, 32'd0);
        rd_check("rst_resp_cnt", R_RESP, 32'd0);
        rd_check("rst_lat", R_LAT, 32'd0);
        rd_check("rst_status", R_STATUS, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
